// File: rtl/byteen_regfile.sv
// Byte-lane-masked register bank: per-lane writes, dirty tracking, bulk clear, range-error flags.
// Read latency 1 cycle with same-edge write forwarding; no backpressure, every request is accepted.
module byteen_regfile #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W/8-1:0] wr_byteena,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clr,
    input  logic [DEPTH-1:0]  dirty_clr,
    output logic [DEPTH-1:0]  dirty,
    output logic              wr_err,
    output logic              rd_err
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]             dirty_q, dirty_d;
    logic [DATA_W-1:0]            rd_data_q, rd_data_d;
    logic                         rd_valid_q, rd_valid_d;
    logic                         rd_err_q, rd_err_d;
    logic                         wr_err_q, wr_err_d;

    always_comb begin
        mem_d      = mem_q;
        dirty_d    = dirty_q & ~dirty_clr;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_en;
        rd_err_d   = rd_en && ({1'b0, rd_addr} >= DEPTH_L);
        wr_err_d   = wr_en && ({1'b0, wr_addr} >= DEPTH_L);

        for (int k = 0; k < DEPTH; k++) begin
            if (wr_en && (wr_addr == ADDR_W'(k)) && (|wr_byteena)) begin
                dirty_d[k] = 1'b1;
                for (int i = 0; i < NB; i++) begin
                    if (wr_byteena[i]) begin
                        mem_d[k][8*i +: 8] = wr_data[8*i +: 8];
                    end
                end
            end
        end

        if (clr) begin
            mem_d   = '0;
            dirty_d = '0;
        end

        // Reading the post-write/post-clear image gives per-lane forwarding for free.
        if (rd_en) begin
            rd_data_d = '0;
            for (int k = 0; k < DEPTH; k++) begin
                if (rd_addr == ADDR_W'(k)) begin
                    rd_data_d = mem_d[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q      <= '0;
            dirty_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            dirty_q    <= dirty_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            wr_err_q   <= wr_err_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign wr_err   = wr_err_q;
    assign dirty    = dirty_q;

endmodule

// File: tb/tb_byteen_regfile.sv
// Bench for byteen_regfile: a DEPTH=4 instance for the main features, a DEPTH=3 one for range errors.
module tb_byteen_regfile;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        wr_en = 0, rd_en = 0, clr = 0;
    logic [1:0]  wr_addr = 0, rd_addr = 0, wr_byteena = 0;
    logic [15:0] wr_data = 0;
    logic [3:0]  dirty_clr = 0;
    logic [15:0] rd_data;
    logic        rd_valid, wr_err, rd_err;
    logic [3:0]  dirty;

    logic        b_wr_en = 0, b_rd_en = 0, b_clr = 0;
    logic [1:0]  b_wr_addr = 0, b_rd_addr = 0, b_wr_byteena = 0;
    logic [15:0] b_wr_data = 0;
    logic [2:0]  b_dirty_clr = 0;
    logic [15:0] b_rd_data;
    logic        b_rd_valid, b_wr_err, b_rd_err;
    logic [2:0]  b_dirty;

    int n_checks = 0;
    int n_fail   = 0;
    logic [16:0] sb_q[$];   // {rd_err, rd_data} expected, in issue order
    logic [16:0] exp;

    byteen_regfile #(.DATA_W(16), .DEPTH(4), .ADDR_W(2)) u_dut (
        .clk(clk), .resetn(resetn),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_byteena(wr_byteena), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .clr(clr), .dirty_clr(dirty_clr), .dirty(dirty),
        .wr_err(wr_err), .rd_err(rd_err)
    );

    byteen_regfile #(.DATA_W(16), .DEPTH(3), .ADDR_W(2)) u_dut3 (
        .clk(clk), .resetn(resetn),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_byteena(b_wr_byteena), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .clr(b_clr), .dirty_clr(b_dirty_clr), .dirty(b_dirty),
        .wr_err(b_wr_err), .rd_err(b_rd_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [1:0] be, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_byteena = be; wr_data = d;
        tick();
        wr_en = 1'b0; wr_byteena = 2'b00;
    endtask

    // Issue reads to addr a..a+n-1 back to back, one result checked per cycle.
    task automatic read_seq(input string tag, input logic [1:0] a, input int n,
                            input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] ev[4];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        for (int j = 0; j < n; j++) begin
            rd_en = 1'b1; rd_addr = a + 2'(j);
            sb_q.push_back({1'b0, ev[j]});
            tick();
            n_checks++;
            if (rd_valid !== 1'b1 || sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s_valid[%0d]: rd_valid=%b queued=%0d, required 1", tag, j, rd_valid, sb_q.size());
            end else begin
                exp = sb_q.pop_front();
                n_checks++;
                if ({rd_err, rd_data} !== exp) begin
                    n_fail++;
                    $display("FAIL %s_data[%0d]: err/data=%b/%h, required %b/%h", tag, j, rd_err, rd_data, exp[16], exp[15:0]);
                end
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_checks++;
        if ({rd_data, rd_valid, dirty, wr_err, rd_err} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: data=%h vld=%b dirty=%b werr=%b rerr=%b, required all 0", rd_data, rd_valid, dirty, wr_err, rd_err);
        end
        #2 resetn = 1'b1;
        tick();
    endtask

    task automatic test_full_write();
        wr(2'd1, 2'b11, 16'hA5C3);
        read_seq("full", 2'd1, 1, 16'hA5C3, 0, 0, 0);
        n_checks++;
        if (dirty !== 4'b0010) begin n_fail++; $display("FAIL full_dirty: %b, required 0010", dirty); end
        tick();
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 16'hA5C3) begin
            n_fail++; $display("FAIL read_hold: vld=%b data=%h, required 0/a5c3", rd_valid, rd_data);
        end
    endtask

    task automatic test_partial_write();
        wr(2'd2, 2'b11, 16'h1234);
        wr(2'd2, 2'b10, 16'hFF00);
        read_seq("partial", 2'd2, 1, 16'hFF34, 0, 0, 0);
        wr(2'd2, 2'b00, 16'hFFFF);
        wr(2'd3, 2'b00, 16'hFFFF);
        n_checks++;
        if (wr_err !== 1'b0) begin n_fail++; $display("FAIL be0_no_err: wr_err=%b, required 0", wr_err); end
        read_seq("be0", 2'd2, 1, 16'hFF34, 0, 0, 0);
        n_checks++;
        if (dirty !== 4'b0110) begin n_fail++; $display("FAIL be0_dirty: %b, required 0110", dirty); end
    endtask

    task automatic test_forwarding();
        wr(2'd0, 2'b11, 16'h7711);
        wr_en = 1'b1; wr_addr = 2'd0; wr_byteena = 2'b01; wr_data = 16'h00EE;
        read_seq("fwd", 2'd0, 1, 16'h77EE, 0, 0, 0);
        wr_en = 1'b0;
        read_seq("fwd_stored", 2'd0, 1, 16'h77EE, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        read_seq("b2b", 2'd0, 4, 16'h77EE, 16'hA5C3, 16'hFF34, 16'h0000);
        n_checks++;
        if (dirty !== 4'b0111) begin n_fail++; $display("FAIL b2b_dirty: %b, required 0111", dirty); end
    endtask

    task automatic test_range_err();
        b_wr_en = 1'b1; b_wr_addr = 2'd2; b_wr_byteena = 2'b11; b_wr_data = 16'hBEEF;
        tick();
        b_wr_addr = 2'd3; b_wr_data = 16'hDEAD;
        tick();
        b_wr_en = 1'b0;
        n_checks++;
        if (b_wr_err !== 1'b1 || b_dirty !== 3'b100) begin
            n_fail++; $display("FAIL oor_write: wr_err=%b dirty=%b, required 1/100", b_wr_err, b_dirty);
        end
        b_rd_en = 1'b1; b_rd_addr = 2'd2;
        tick();
        n_checks++;
        if (b_wr_err !== 1'b0 || b_rd_data !== 16'hBEEF || b_rd_err !== 1'b0 || b_rd_valid !== 1'b1) begin
            n_fail++; $display("FAIL inrange_read: werr=%b data=%h rerr=%b vld=%b, required 0/beef/0/1", b_wr_err, b_rd_data, b_rd_err, b_rd_valid);
        end
        b_rd_addr = 2'd3;
        tick();
        b_rd_en = 1'b0;
        n_checks++;
        if (b_rd_data !== 16'h0000 || b_rd_err !== 1'b1 || b_rd_valid !== 1'b1) begin
            n_fail++; $display("FAIL oor_read: data=%h rerr=%b vld=%b, required 0000/1/1", b_rd_data, b_rd_err, b_rd_valid);
        end
        tick();
        n_checks++;
        if (b_rd_err !== 1'b0 || b_rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL oor_read_pulse: rerr=%b vld=%b, required 0/0", b_rd_err, b_rd_valid);
        end
    endtask

    task automatic test_clr();
        wr(2'd0, 2'b11, 16'h1111);
        wr(2'd1, 2'b11, 16'h2222);
        wr(2'd2, 2'b11, 16'h3333);
        wr(2'd3, 2'b11, 16'h4444);
        n_checks++;
        if (dirty !== 4'b1111) begin n_fail++; $display("FAIL clr_pre_dirty: %b, required 1111", dirty); end
        clr = 1'b1;
        wr_en = 1'b1; wr_addr = 2'd2; wr_byteena = 2'b11; wr_data = 16'hABCD;
        read_seq("clr_same_edge", 2'd2, 1, 16'h0000, 0, 0, 0);
        clr = 1'b0; wr_en = 1'b0;
        n_checks++;
        if (dirty !== 4'b0000) begin n_fail++; $display("FAIL clr_dirty: %b, required 0000", dirty); end
        read_seq("clr_after", 2'd0, 4, 16'h0, 16'h0, 16'h0, 16'h0);
        n_checks++;
        if (dirty !== 4'b0000) begin n_fail++; $display("FAIL clr_dirty_after: %b, required 0000", dirty); end
        b_clr = 1'b1; b_wr_en = 1'b1; b_wr_addr = 2'd3; b_wr_byteena = 2'b11;
        tick();
        b_clr = 1'b0; b_wr_en = 1'b0;
        n_checks++;
        if (b_wr_err !== 1'b1 || b_dirty !== 3'b000) begin
            n_fail++; $display("FAIL clr_oor_write: wr_err=%b dirty=%b, required 1/000", b_wr_err, b_dirty);
        end
    endtask

    task automatic test_dirty_set_wins();
        wr(2'd1, 2'b11, 16'h0101);
        wr(2'd2, 2'b10, 16'h0200);
        dirty_clr = 4'b0110;
        wr(2'd2, 2'b01, 16'h00AA);
        dirty_clr = 4'b0000;
        n_checks++;
        if (dirty !== 4'b0100) begin n_fail++; $display("FAIL dirty_set_wins: %b, required 0100", dirty); end
    endtask

    task automatic test_async_reset();
        read_seq("pre_rst", 2'd1, 2, 16'h0101, 16'h02AA, 0, 0);
        rd_en = 1'b1; rd_addr = 2'd3;
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({rd_data, rd_valid, dirty, wr_err, rd_err} !== 23'd0) begin
            n_fail++; $display("FAIL async_reset: data=%h vld=%b dirty=%b werr=%b rerr=%b, required all 0", rd_data, rd_valid, dirty, wr_err, rd_err);
        end
        tick();
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h0) begin
            n_fail++; $display("FAIL reset_held: vld=%b data=%h, required 0/0000", rd_valid, rd_data);
        end
        rd_en = 1'b0;
        #2 resetn = 1'b1;
        tick();
        read_seq("post_rst", 2'd0, 4, 16'h0, 16'h0, 16'h0, 16'h0);
        wr(2'd1, 2'b11, 16'h5A5A);
        read_seq("resume", 2'd1, 1, 16'h5A5A, 0, 0, 0);
        n_checks++;
        if (dirty !== 4'b0010) begin n_fail++; $display("FAIL resume_dirty: %b, required 0010", dirty); end
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_partial_write();
        test_forwarding();
        test_back_to_back();
        test_range_err();
        test_clr();
        test_dirty_set_wins();
        test_async_reset();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/byteen_regfile.md
Name: byteen_regfile

Overview:
Parametrised byte-lane-masked register bank, successor to the single 16-bit byte-enabled register. Holds DEPTH words of DATA_W bits. Each write updates only the enabled byte lanes. Provides a one-cycle-latency read port with same-cycle write forwarding, per-entry dirty tracking, a synchronous bulk clear and address-range error flags. Sits between a bus slave decoder and control/status consumers.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of 8 and at least 8
DEPTH, 4, number of words; need not be a power of two
ADDR_W, 2, address width; must satisfy 2**ADDR_W >= DEPTH
NB, DATA_W/8, number of byte lanes; derived, not overridden

Ports:
clk  input  1  rising-edge clock
resetn  input  1  reset; one clock, asynchronous active-low reset
wr_en  input  1  write request, sampled on the clk rising edge
wr_addr  input  ADDR_W  write word address
wr_byteena  input  NB  lane enables; bit i covers wr_data[8i+7:8i]
wr_data  input  DATA_W  write data
rd_en  input  1  read request
rd_addr  input  ADDR_W  read word address
rd_data  output  DATA_W  registered read data
rd_valid  output  1  pulses high with each read result
clr  input  1  synchronous clear of all entries and dirty flags
dirty_clr  input  DEPTH  per-entry dirty-flag clear mask
dirty  output  DEPTH  bit k high when entry k has been written since the last clear
wr_err  output  1  one-cycle pulse on an out-of-range write
rd_err  output  1  one-cycle pulse, aligned with rd_valid, on an out-of-range read

Behaviour:
- Reset (resetn=0, asynchronous, takes effect immediately, including mid-operation): all entries 0, rd_data 0, rd_valid 0, dirty all 0, wr_err 0, rd_err 0. Outputs stay at these values while resetn=0.
- Write, on a rising edge with wr_en=1 and wr_addr<DEPTH:
  - For each lane i with wr_byteena[i]=1, entry[wr_addr] lane i takes wr_data lane i.
  - Lanes with wr_byteena[i]=0 hold their value.
  - wr_byteena all 0: no data change and no dirty set. This is not an error.
- Write with wr_addr>=DEPTH: storage and dirty are unchanged; wr_err=1 for the next cycle only.
- Read: rd_en=1 at edge N gives rd_data and rd_valid=1 after edge N (one-cycle latency).
  - With rd_en=0, rd_valid=0 and rd_data holds its last value.
  - Back-to-back reads give one result per cycle.
- Read with rd_addr>=DEPTH: rd_data=0, rd_valid=1, rd_err=1 for that cycle.
- Read and write on the same edge to the same in-range address: forwarding applies per lane. Enabled lanes return the new wr_data bytes; disabled lanes return the stored bytes.
- clr=1 on an edge:
  - All entries go to 0 and all dirty bits go to 0.
  - clr beats a simultaneous write: the write is dropped, dirty stays 0, and wr_err still flags an out-of-range wr_addr.
  - A simultaneous read returns 0 with rd_valid=1.
- Dirty tracking:
  - dirty[k] sets on an in-range write to k with at least one lane enabled.
  - dirty[k] clears on an edge with dirty_clr[k]=1.
  - Set and clear of the same k on the same edge: set wins.
- There are no combinational paths from inputs to outputs. All outputs are registered.

Test Plan:
- Reset, then write addr 1, byteena 2'b11, data 16'hA5C3; read addr 1 -> one cycle later rd_data=16'hA5C3, rd_valid=1, dirty=4'b0010.
- Entry 2 = 16'h1234; write byteena 2'b10, data 16'hFF00 -> read gives 16'hFF34. Then write byteena 2'b00, data 16'hFFFF -> read still 16'hFF34.
- Same-edge write addr 0 (byteena 2'b01, data 16'h00EE) and read addr 0 with stored 16'h7711 -> rd_data=16'h77EE on the next cycle.
- DEPTH=3 instance: write addr 3 -> wr_err one-cycle pulse, no dirty change. Read addr 3 -> rd_data=0, rd_valid=1, rd_err=1.
- Entries hold nonzero data, dirty=4'b1111. Assert clr together with a write to addr 2 and a read of addr 2 -> rd_data=0, then all reads return 0 and dirty=0. Separately, dirty_clr=4'b0100 with a write to addr 2 on the same edge -> dirty[2] stays 1.
- Drop resetn asynchronously between clock edges during back-to-back reads -> rd_valid, rd_data, dirty and all entries go to 0 without waiting for a clock edge. After resetn releases, normal operation resumes.
